// File: rtl/rfrac_bin_pack_stg3.sv
// Output packer for the residue-to-fractional binary converter: saturates sign/magnitude
// digits into a 64-bit two's-complement word and buffers it in a show-ahead FIFO.
module rfrac_bin_pack_stg3 #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 sign_in,
  input  logic [15:0]          B0_in,
  input  logic [15:0]          B1_in,
  input  logic [15:0]          B2_in,
  input  logic [15:0]          B3_in,
  input  logic                 OV1_in,
  input  logic [17:0]          OV2_in,
  output logic [63:0]          dout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sat_flag,
  output logic [CNT_WIDTH-1:0] sat_count,
  output logic [CNT_WIDTH-1:0] drop_count
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [63:0] PosMax = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NegMax = 64'h8000_0000_0000_0000;
  localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic        s1_valid_q, s1_sign_q, s1_ovf_q;
  logic [63:0] s1_mag_q;
  logic        s2_valid_q, s2_sat_q, s2_sat_d;
  logic [63:0] s2_res_q, s2_res_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_mag_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= sign_in;
        s1_ovf_q  <= OV1_in | (|OV2_in);
        s1_mag_q  <= {B3_in, B2_in, B1_in, B0_in};
      end
    end
  end

  // Negative range reaches 2^63, so only a set MSB with any lower bit overflows.
  always_comb begin
    s2_sat_d = 1'b0;
    s2_res_d = s1_mag_q;
    if (!s1_sign_q) begin
      if (s1_ovf_q || s1_mag_q[63]) begin
        s2_sat_d = 1'b1;
        s2_res_d = PosMax;
      end
    end else if (s1_ovf_q || (s1_mag_q[63] && (|s1_mag_q[62:0]))) begin
      s2_sat_d = 1'b1;
      s2_res_d = NegMax;
    end else begin
      s2_res_d = ~s1_mag_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sat_q   <= 1'b0;
      s2_res_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sat_q <= s2_sat_d;
        s2_res_q <= s2_res_d;
      end
    end
  end

  logic [64:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [64:0] last_q;
  logic [CNT_WIDTH-1:0] sat_cnt_q, drop_cnt_q;
  logic empty, full, pop, push, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign push  = s2_valid_q && (!full || pop);
  assign drop  = s2_valid_q && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s2_sat_q, s2_res_q};
    end
  end

  // last_q keeps the most recently popped head so dout holds while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_q     <= '0;
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q[AW-1:0]];
      end
      if (push && s2_sat_q && (sat_cnt_q != CntMax)) begin
        sat_cnt_q <= sat_cnt_q + CntOne;
      end
      if (drop && (drop_cnt_q != CntMax)) begin
        drop_cnt_q <= drop_cnt_q + CntOne;
      end
    end
  end

  assign out_valid         = !empty;
  assign {sat_flag, dout}  = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
  assign sat_count         = sat_cnt_q;
  assign drop_count        = drop_cnt_q;

endmodule

// File: tb/tb_rfrac_bin_pack_stg3.sv
// Bench for rfrac_bin_pack_stg3: directed scenarios plus randomized traffic checked
// against a queue-based model of the packer's value rules and buffering.
module tb_rfrac_bin_pack_stg3;
  localparam int Depth  = 4;
  localparam int CntW   = 4;
  localparam int CntMax = 15;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic inValid = 1'b0;
  logic signIn = 1'b0;
  logic [15:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0;
  logic ov1 = 1'b0;
  logic [17:0] ov2 = '0;
  logic outReady = 1'b1;
  logic [63:0] dout;
  logic outValid, satFlag;
  logic [CntW-1:0] satCount, dropCount;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  rfrac_bin_pack_stg3 #(.FIFO_DEPTH(Depth), .CNT_WIDTH(CntW)) dut (
    .clk(clk), .rst_n(rstN), .in_valid(inValid), .sign_in(signIn),
    .B0_in(b0), .B1_in(b1), .B2_in(b2), .B3_in(b3),
    .OV1_in(ov1), .OV2_in(ov2),
    .dout(dout), .out_valid(outValid), .out_ready(outReady), .sat_flag(satFlag),
    .sat_count(satCount), .drop_count(dropCount)
  );

  // Signed value of a sign/magnitude word clamped to the 64-bit two's-complement range.
  function automatic logic [64:0] refConv(input logic s, input logic [63:0] m,
                                          input logic o1, input logic [17:0] o2);
    logic ovf;
    ovf = o1 || (o2 != 18'd0);
    if (!s) begin
      if (ovf || m > 64'h7FFF_FFFF_FFFF_FFFF) return {1'b1, 64'h7FFF_FFFF_FFFF_FFFF};
      return {1'b0, m};
    end
    if (ovf || m > 64'h8000_0000_0000_0000) return {1'b1, 64'h8000_0000_0000_0000};
    return {1'b0, 64'd0 - m};
  endfunction

  logic [64:0] mq[$];
  logic [64:0] mLast = '0;
  logic [64:0] p1 = '0, p2 = '0;
  logic p1v = 1'b0, p2v = 1'b0;
  int mSat = 0, mDrop = 0;

  // Two-cycle conversion delay followed by a bounded queue.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mq.delete();
      mLast = '0; p1 = '0; p2 = '0; p1v = 1'b0; p2v = 1'b0; mSat = 0; mDrop = 0;
    end else begin
      if (outReady && mq.size() > 0) mLast = mq.pop_front();
      if (p2v) begin
        if (mq.size() < Depth) begin
          mq.push_back(p2);
          if (p2[64] && mSat < CntMax) mSat++;
        end else if (mDrop < CntMax) begin
          mDrop++;
        end
      end
      p2 = p1; p2v = p1v;
      p1v = inValid;
      p1 = refConv(signIn, {b3, b2, b1, b0}, ov1, ov2);
    end
  end

  function automatic logic [64:0] expHead();
    return (mq.size() > 0) ? mq[0] : mLast;
  endfunction

  task automatic driveWord(input logic s, input logic [63:0] m, input logic o1, input logic [17:0] o2);
    inValid = 1'b1; signIn = s; {b3, b2, b1, b0} = m; ov1 = o1; ov2 = o2;
    @(negedge clk);
    inValid = 1'b0; ov1 = 1'b0; ov2 = '0;
  endtask

  task automatic test_reset();
    rstN = 1'b0; outReady = 1'b1;
    repeat (2) @(negedge clk);
    nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %0b want 0", outValid); end
    nCompared++; if (dout !== 64'd0) begin nMismatched++; $display("[TB] FAIL reset_dout: got %h want 0", dout); end
    nCompared++; if (satFlag !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_sat_flag: got %0b want 0", satFlag); end
    nCompared++; if (satCount !== '0 || dropCount !== '0) begin nMismatched++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", satCount, dropCount); end
    rstN = 1'b1;
  endtask

  task automatic test_positive();
    outReady = 1'b1;
    driveWord(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0, 18'd0);
    @(negedge clk);
    nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL pos_early_valid: got %0b want 0", outValid); end
    @(negedge clk);
    nCompared++; if (outValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL pos_latency: got %0b want 1", outValid); end
    nCompared++; if (dout !== 64'h1234_5678_9ABC_DEF0 || satFlag !== 1'b0) begin nMismatched++; $display("[TB] FAIL pos_value: got %h/%0b want 123456789abcdef0/0", dout, satFlag); end
    @(negedge clk);
  endtask

  task automatic test_convert();
    logic        cs [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] cm [6] = '{64'd1, 64'h8000_0000_0000_0000, 64'd0, 64'd5, 64'd5, 64'h8000_0000_0000_0000};
    logic        co1[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [17:0] co2[6] = '{18'd0, 18'd0, 18'd0, 18'd0, 18'd1, 18'd0};
    logic [63:0] ev [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0,
                            64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
    logic        es [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    outReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      driveWord(cs[i], cm[i], co1[i], co2[i]);
      repeat (2) @(negedge clk);
      nCompared++; if (outValid !== 1'b1 || dout !== ev[i] || satFlag !== es[i]) begin nMismatched++; $display("[TB] FAIL convert_%0d: got v=%0b %h/%0b want v=1 %h/%0b", i, outValid, dout, satFlag, ev[i], es[i]); end
      @(negedge clk);
    end
    nCompared++; if (satCount !== 4'd3) begin nMismatched++; $display("[TB] FAIL sat_count: got %0d want 3", satCount); end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    for (int i = 1; i <= 6; i++) driveWord(1'b0, 64'(i), 1'b0, 18'd0);
    repeat (2) @(negedge clk);
    nCompared++; if (dropCount !== 4'd2) begin nMismatched++; $display("[TB] FAIL bp_drop_count: got %0d want 2", dropCount); end
    for (int i = 1; i <= 4; i++) begin
      nCompared++; if (outValid !== 1'b1 || dout !== 64'(i)) begin nMismatched++; $display("[TB] FAIL bp_order_%0d: got v=%0b %h want v=1 %h", i, outValid, dout, 64'(i)); end
      outReady = 1'b1;
      @(negedge clk);
    end
    nCompared++; if (outValid !== 1'b0 || dout !== 64'd4) begin nMismatched++; $display("[TB] FAIL bp_empty: got v=%0b %h want v=0 4", outValid, dout); end
  endtask

  task automatic test_back_to_back();
    outReady = 1'b0;
    for (int i = 11; i <= 15; i++) driveWord(1'b0, 64'(i), 1'b0, 18'd0);
    @(negedge clk);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    nCompared++; if (dropCount !== 4'd2) begin nMismatched++; $display("[TB] FAIL full_pushpop_drop: got %0d want 2", dropCount); end
    for (int i = 12; i <= 15; i++) begin
      nCompared++; if (outValid !== 1'b1 || dout !== 64'(i)) begin nMismatched++; $display("[TB] FAIL full_pushpop_order_%0d: got v=%0b %h want v=1 %h", i, outValid, dout, 64'(i)); end
      outReady = 1'b1;
      @(negedge clk);
    end
    nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_pushpop_empty: got %0b want 0", outValid); end
  endtask

  task automatic test_reset_midstream();
    outReady = 1'b0;
    for (int i = 21; i <= 23; i++) driveWord(1'b0, 64'(i), 1'b0, 18'd0);
    repeat (2) @(negedge clk);
    nCompared++; if (outValid !== 1'b1 || dout !== 64'd21) begin nMismatched++; $display("[TB] FAIL mid_buffered: got v=%0b %h want v=1 15", outValid, dout); end
    #2 rstN = 1'b0;
    #1;
    nCompared++; if (outValid !== 1'b0 || dout !== 64'd0) begin nMismatched++; $display("[TB] FAIL mid_async_clear: got v=%0b %h want v=0 0", outValid, dout); end
    nCompared++; if (satCount !== '0 || dropCount !== '0) begin nMismatched++; $display("[TB] FAIL mid_counts: got %0d/%0d want 0/0", satCount, dropCount); end
    @(negedge clk);
    rstN = 1'b1; outReady = 1'b1;
    driveWord(1'b1, 64'd77, 1'b0, 18'd0);
    @(negedge clk);
    nCompared++; if (outValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_early_valid: got %0b want 0", outValid); end
    @(negedge clk);
    nCompared++; if (outValid !== 1'b1 || dout !== (64'd0 - 64'd77)) begin nMismatched++; $display("[TB] FAIL mid_restart: got v=%0b %h want v=1 %h", outValid, dout, 64'd0 - 64'd77); end
    @(negedge clk);
  endtask

  task automatic test_counter_saturation();
    outReady = 1'b0;
    for (int i = 0; i < 24; i++) driveWord(1'b0, 64'(100 + i), 1'b0, 18'd0);
    repeat (2) @(negedge clk);
    nCompared++; if (dropCount !== 4'd15) begin nMismatched++; $display("[TB] FAIL drop_saturate: got %0d want 15", dropCount); end
    nCompared++; if (dout !== 64'd100) begin nMismatched++; $display("[TB] FAIL drop_keep_head: got %h want 64", dout); end
    outReady = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] m;
    logic [64:0] eh;
    for (int c = 0; c < 400; c++) begin
      eh = expHead();
      nCompared++; if (outValid !== (mq.size() > 0)) begin nMismatched++; $display("[TB] FAIL rnd_valid@%0d: got %0b want %0b", c, outValid, mq.size() > 0); end
      nCompared++; if ({satFlag, dout} !== eh) begin nMismatched++; $display("[TB] FAIL rnd_head@%0d: got %0b/%h want %0b/%h", c, satFlag, dout, eh[64], eh[63:0]); end
      nCompared++; if (satCount !== CntW'(mSat) || dropCount !== CntW'(mDrop)) begin nMismatched++; $display("[TB] FAIL rnd_counts@%0d: got %0d/%0d want %0d/%0d", c, satCount, dropCount, mSat, mDrop); end
      case ($urandom_range(0, 5))
        0: m = {$urandom, $urandom};
        1: m = 64'h8000_0000_0000_0000;
        2: m = 64'd0;
        3: m = 64'($urandom_range(0, 255));
        4: m = 64'h7FFF_FFFF_FFFF_FFFF;
        default: m = 64'h8000_0000_0000_0001;
      endcase
      inValid = ($urandom_range(0, 3) != 0);
      signIn = 1'($urandom_range(0, 1));
      {b3, b2, b1, b0} = m;
      ov1 = ($urandom_range(0, 9) == 0);
      ov2 = ($urandom_range(0, 9) == 0) ? (18'd1 << $urandom_range(0, 17)) : 18'd0;
      outReady = (c % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    inValid = 1'b0; ov1 = 1'b0; ov2 = '0; outReady = 1'b1;
    repeat (8) @(negedge clk);
    nCompared++; if (outValid !== 1'b0 || mq.size() != 0) begin nMismatched++; $display("[TB] FAIL rnd_drain: got v=%0b want v=0 (model %0d)", outValid, mq.size()); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_convert();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_counter_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/rfrac_bin_pack_stg3.md
# rfrac_bin_pack_stg3

Output packer for the residue-to-fractional binary converter. It consumes the free-running stage-2 conversion outputs: sign, four 16-bit binary digit words B0..B3 (B3 most significant), and overflow indicators OV1/OV2. It packs them into a saturated 64-bit two's-complement word and buffers the result in a small show-ahead FIFO behind a valid/ready interface. The upstream pipeline cannot stall, so the FIFO absorbs downstream backpressure and counts dropped words.

## Interface
- FIFO_DEPTH, 4: result FIFO entries; power of two, 2..16.
- CNT_WIDTH, 16: width of the saturating event counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  qualifies the input word this cycle. Driven by a valid bit delay-matched to the converter; no input ready exists.
- sign_in  in  1  1 = value is negative; B3..B0 hold the magnitude.
- B0_in, B1_in, B2_in, B3_in  in  16 each  magnitude digits; mag = {B3,B2,B1,B0}.
- OV1_in  in  1  final carry-out overflow.
- OV2_in  in  18  residual high word; any nonzero bit is overflow.
- dout  out  64  two's-complement result, FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid && out_ready.
- sat_flag  out  1  head entry was saturated; travels with dout.
- sat_count  out  CNT_WIDTH  number of saturated words written; saturates at all-ones.
- drop_count  out  CNT_WIDTH  number of words lost to a full FIFO; saturates at all-ones.

## Operation
- **S1 (register):** capture in_valid, sign, mag (64 b), and ovf = OV1_in | (|OV2_in).
- **S2 (convert):**
  - Positive (sign=0): if ovf or mag[63]=1, result = 0x7FFF_FFFF_FFFF_FFFF and sat=1. Otherwise result = mag and sat=0.
  - Negative (sign=1): if ovf or mag > 2^63, result = 0x8000_0000_0000_0000 and sat=1. Otherwise result = (~mag)+1 and sat=0. mag = 2^63 exactly gives 0x8000_0000_0000_0000 with sat=0.
  - Negative zero (sign=1, mag=0) gives 0 with sat=0.
- **S2 valid handling:** the valid bit propagates through S1/S2. The datapath registers load only when valid, to limit toggle.
- **FIFO write:** on S2 valid, write {sat, result} into the FIFO. sat_count increments when sat=1.
- **FIFO organisation:** show-ahead; dout and sat_flag always reflect the head entry. Read/write pointers carry one extra wrap bit; full = pointers equal except the MSB.
- **Full and no pop in the same cycle:** the word is discarded, drop_count increments, FIFO contents are untouched, and sat_count is not incremented for the dropped word.
- **Full with a pop in the same cycle:** push and pop both occur; occupancy is unchanged and there is no drop.
- **Empty:** out_ready is ignored, and dout/sat_flag hold their last value, or 0 after reset.
- **Counters:** hold at 2^CNT_WIDTH−1 and never wrap.

## Timing
- Input sampled at edge N. Result enters the FIFO at edge N+2. out_valid rises after edge N+2 when the FIFO was empty. Total latency: 3 register stages.
- Throughput: one word per clock sustained while out_ready=1; no bubbles.
- A pop takes effect at the edge where out_valid && out_ready. The next head appears in the same cycle after that edge.
- Reset (asynchronous assert, synchronous-style release on rst_n rising):
  - Cleared: pipeline valids, FIFO pointers, out_valid, dout, sat_flag, sat_count, drop_count.
  - Words in flight in S1/S2 at reset are lost and not counted.
- Reset mid-operation: on release, the first word is accepted on the first clock with rst_n=1. The FIFO restarts empty.

## Test plan
- **Positive in range:** sign=0, B3..B0 = 0x1234,0x5678,0x9ABC,0xDEF0, OV=0 -> dout = 0x123456789ABCDEF0, sat_flag=0, out_valid 3 cycles after input, out_ready=1.
- **Negative:** sign=1, mag=1 -> dout = 0xFFFF_FFFF_FFFF_FFFF.
- **Negative boundary:** sign=1, mag=0x8000_0000_0000_0000 -> dout = 0x8000_0000_0000_0000, sat=0.
- **Negative zero:** sign=1, mag=0 -> dout = 0, sat=0.
- **Saturation:**
  - sign=0, OV1=1 -> 0x7FFF…FFFF, sat_flag=1.
  - sign=1, OV2=0x00001 -> 0x8000…0000, sat_flag=1.
  - sign=0, mag=0x8000…0000, OV=0 -> 0x7FFF…FFFF, sat_flag=1.
  - Expected after these three: sat_count=3.
- **Backpressure/drop:** out_ready=0, 6 consecutive valid words 1..6 with FIFO_DEPTH=4 -> words 1..4 retained, drop_count=2. Then out_ready=1 -> dout 1,2,3,4 on consecutive cycles, then out_valid=0.
- **Full plus simultaneous push/pop:** with the FIFO full, out_ready=1 and one new word arriving -> no drop, occupancy stays 4, order preserved.
- **Reset mid-stream:** assert rst_n=0 while 3 entries are buffered -> out_valid=0 and both counters 0 immediately (asynchronous). After release, a new word appears 3 cycles after input.
- **Counter saturation:** with CNT_WIDTH=4, 20 drops -> drop_count holds at 15.
